inst_fetch_buffer: RTL
======================

// Module: inst_fetch_buffer
// PURPOSE
//   Instruction fetch front end upstream of the mips core. Owns the fetch PC,
//   issues reads to the instruction RAM (1-cycle synchronous read latency),
//   queues returned words with their PC in a small FIFO, and presents them to
//   the core over a valid/ready handshake. Branch/jump redirects flush it.
// PARAMETERS
//   DEPTH     4             FIFO entries; power of two, >= 2
//   RESET_PC  32'h0000_0000 fetch PC after reset; bits [1:0] must be 0
// PORTS
//   clk            in   1   clock; all state updates on the rising edge
//   rst            in   1   synchronous, active-high reset
//   redirect       in   1   taken branch/jump from the core; flush and refetch
//   redirect_pc    in   32  new fetch address; bits [1:0] ignored
//   inst_ram_ena   out  1   instruction RAM read enable (one request/cycle)
//   inst_ram_addr  out  32  instruction RAM byte address, word aligned
//   inst_ram_rdata in   32  read data, valid the cycle after inst_ram_ena
//   instr          out  32  head instruction; 32'h0 when instr_valid=0
//   instr_pc       out  32  PC of head instruction; 32'h0 when instr_valid=0
//   instr_valid    out  1   head entry present
//   instr_ready    in   1   core accepts head (pop when valid & ready)
// BEHAVIOUR
// - Reset: fpc=RESET_PC, FIFO empty, inflight=0; instr_valid=0, instr=0,
//   instr_pc=0, inst_ram_ena=0, inst_ram_addr=RESET_PC.
// - Issue: inst_ram_ena=1 iff !rst && !redirect && (count+inflight)<DEPTH,
//   using registered count/inflight (no same-cycle pop lookahead).
//   inst_ram_addr=fpc combinationally. On issue: fpc<=fpc+4 (wraps
//   32'hFFFF_FFFC->0), inflight<=1, req_pc<=fpc; else inflight<=0.
// - Response: when inflight=1 and no kill, {req_pc, inst_ram_rdata} is pushed.
//   Credit rule guarantees push never overflows.
// - Pop: valid&ready removes head; simultaneous push+pop keeps count.
// - Redirect (highest priority): at edge, FIFO emptied, fpc<=redirect_pc&~3,
//   inflight<=0, response of a request issued in the redirect cycle or the
//   cycle before is dropped; no issue in the redirect cycle. First request
//   to redirect_pc issues the next cycle. Pop in redirect cycle is honoured
//   by the handshake but the flush wins for stored state.
// - Read/write pointers log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
// - rst asserted mid-operation overrides redirect and in-flight data.
// - Latency (no bypass): request cycle t -> instr_valid at t+2.
// CONFIGURATION
//   FETCH_BYPASS_EN defined: when FIFO empty and a non-killed response arrives,
//   instr/instr_pc/instr_valid are driven directly from inst_ram_rdata/req_pc
//   at t+1; if instr_ready=1 that cycle the word is not pushed.
//   Undefined: all responses go through the FIFO; latency t+2; outputs are
//   purely FIFO-head driven (no RAM-data-to-output combinational path).
// STRUCTURE
//   fetch_defs.vh: localparams INSTR_W=32, PC_STEP=4, NOP=32'h0, DEPTH_LOG2
//   helper function. Sub-module fetch_fifo (DEPTH x 64b sync FIFO, push/pop/
//   flush, count out); credit, fpc, inflight and kill logic in top.
// TESTING
// 1 Reset, ready=1: addresses 0,4,8,.. issued every cycle; instr_pc 0 valid
//   at cycle 2 after reset release (cycle 1 with FETCH_BYPASS_EN).
// 2 ready=0 held: exactly DEPTH requests issued (addr 0..0xC), ena then 0,
//   instr_valid=1 with instr_pc=0; release ready -> 0,4,8,0xC popped in order.
// 3 redirect to 0x100 with 3 entries queued and one in flight: next cycle
//   valid=0, in-flight word never appears; next delivered instr_pc=0x100.
// 4 redirect_pc=0x203 -> fetch from 0x200; fpc at 0xFFFF_FFFC -> next 0x0.
// 5 Alternating ready 1/0 with push+pop same cycle: no loss, no duplicate,
//   count never exceeds DEPTH (assertion).
// 6 rst asserted while FIFO full and request in flight: next cycle all
//   outputs at reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: word width, fetch step,
// FIFO entry layout and a log2 helper for pointer sizing.
package inst_fetch_buffer_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Smallest n with 2**n >= depth.
  function automatic int depth_log2(input int depth);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries. Flush empties it
// in one edge and wins over a concurrent push or pop; head is read combinationally.
module inst_fetch_buffer_fetch_fifo
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         empty_o,
  output logic [depth_log2(DEPTH):0]   count_o
);

  localparam int AW = depth_log2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;
  logic [DEPTH-1:0] wr_en;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only accepted when a pop frees a slot this cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = !flush_i && do_push && (wptr_q == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_q[i] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited reads to a
// 1-cycle instruction RAM and queues {pc, instr} for the core. Macro FETCH_BYPASS_EN
// lets a response reach the outputs in its arrival cycle when the queue is empty.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               inst_ram_ena,
  output logic [31:0]        inst_ram_addr,
  input  logic [INSTR_W-1:0] inst_ram_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int AW  = depth_log2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CRW = CW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_push, fifo_pop;
  logic          issue, rsp_valid;
  logic [CRW-1:0] credit_used;
  fetch_entry_t  push_entry, head_entry;

  // Queued entries plus the one request in the RAM pipe must fit in the FIFO.
  assign credit_used  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue        = !rst && !redirect && (credit_used < CRW'(DEPTH));
  assign inst_ram_ena  = issue;
  assign inst_ram_addr = fpc_q;

  // A response arriving during a redirect belongs to the old path and is dropped.
  assign rsp_valid  = inflight_q && !redirect && !rst;
  assign push_entry = {req_pc_q, inst_ram_rdata};

  always_comb begin
    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    if (redirect) begin
      fpc_d = redirect_pc & ~32'h3;
    end else if (issue) begin
      fpc_d      = fpc_q + PC_STEP;
      req_pc_d   = fpc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign fifo_pop = !fifo_empty && instr_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = fifo_empty && rsp_valid;
  // A bypassed word taken by the core in its arrival cycle never enters the FIFO.
  assign fifo_push   = rsp_valid && !(bypass_hit && instr_ready);
  assign instr_valid = !fifo_empty || bypass_hit;

  always_comb begin
    instr    = NOP;
    instr_pc = '0;
    if (!fifo_empty) begin
      instr    = head_entry.instr;
      instr_pc = head_entry.pc;
    end else if (bypass_hit) begin
      instr    = inst_ram_rdata;
      instr_pc = req_pc_q;
    end
  end
`else
  assign fifo_push   = rsp_valid;
  assign instr_valid = !fifo_empty;

  always_comb begin
    instr    = NOP;
    instr_pc = '0;
    if (!fifo_empty) begin
      instr    = head_entry.instr;
      instr_pc = head_entry.pc;
    end
  end
`endif

  inst_fetch_buffer_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (head_entry),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule
